pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central sequencer for the five-stage pipeline: decides every cycle whether each stage register (if_id, id_ex, ex_mem, mem_wb) advances, holds or is cleared to a bubble. Resolves load-use hazards, taken-branch flushes and data-memory wait states. Escalates a stuck memory access to a halt. Sits beside the stage registers in the core top level and drives their new per-stage enable/flush inputs.

## Interface
- MAX_WAIT, default 16: maximum consecutive cycles a data-memory access may stall before halt; legal range 2..255.
- CNT_W, default 16: width of the saturating performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high (compare against common::RESET).
- i_id_rs1_sel  in  5  rs1 index of the instruction in ID.
- i_id_rs2_sel  in  5  rs2 index of the instruction in ID.
- i_id_uses_rs1, i_id_uses_rs2  in  1 each  instruction in ID reads that source.
- i_ex_rd_sel  in  5  destination index in EX (id_ex output).
- i_ex_ctrl_mem_read  in  1  EX instruction is a load.
- i_ex_ctrl_reg_wr_en  in  1  EX instruction writes rd.
- i_ex_branch_taken  in  1  branch/jump in EX resolved taken.
- i_mem_req  in  1  MEM instruction accesses data memory (ex_mem mem_read | mem_write).
- i_dmem_ready  in  1  data memory completes the access this cycle.
- o_pc_en  out  1  PC may update.
- o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1 each  stage register loads.
- o_if_id_flush, o_id_ex_flush, o_mem_wb_flush  out  1 each  stage register loads a bubble (all zeros); flush overrides en.
- o_halt  out  1  core halted on memory timeout; level.
- o_stall_cycles  out  CNT_W  saturating count of cycles with o_pc_en=0.
- o_flush_count  out  CNT_W  saturating count of taken-branch flushes.

## Operation
- States: RUN, MEM_WAIT, HALT. Outputs are Mealy: state plus current inputs.
- Load-use hazard (lu): i_ex_ctrl_mem_read & i_ex_ctrl_reg_wr_en & i_ex_rd_sel≠0 & ((i_id_uses_rs1 & rs1==rd) | (i_id_uses_rs2 & rs2==rd)).
- Memory stall (ms): i_mem_req & ~i_dmem_ready.
- Default (no event): all en=1, all flush=0.
- Priority in RUN and MEM_WAIT, highest first:
  - ms: pc_en, if_id_en, id_ex_en, ex_mem_en=0, o_mem_wb_flush=1. A pending branch stays in EX and resolves after the stall.
  - i_ex_branch_taken: o_if_id_flush=o_id_ex_flush=1, pc_en=1 (PC takes target). lu is ignored. o_flush_count +1.
  - lu: pc_en=if_id_en=0, o_id_ex_flush=1. Exactly one bubble, because the load advances to MEM the next cycle.
- Transitions:
  - RUN→MEM_WAIT on ms; wait_cnt←1.
  - MEM_WAIT with ms: wait_cnt+1. If wait_cnt==MAX_WAIT-1, go to HALT.
  - MEM_WAIT with ~ms: go to RUN; that cycle's outputs follow the RUN rules.
  - HALT is left only by rst. In HALT all en=0, all flush=0, counters frozen.
- Counters saturate at all-ones and never wrap. o_stall_cycles counts RUN/MEM_WAIT cycles with pc_en=0.

## Timing
- Zero-latency control: enables and flushes respond combinationally in the same cycle as the inputs. State, wait_cnt and counters are registered.
- While rst=1:
  - all en=0, all flush=1 (pipeline cleared).
  - o_halt=0, counters 0.
  - state RUN at the next edge.
- rst asserted during MEM_WAIT or HALT returns to RUN with wait_cnt=0 on the following edge.
- o_halt = (state==HALT), registered. It rises on the edge after the MAX_WAIT-th consecutive stalled cycle.
- Stalled-cycle accounting: the ms cycle in RUN counts as cycle 1. Halt follows exactly MAX_WAIT stalled cycles.
- Simultaneous branch and lu: the branch wins, one flush, no bubble count.
- Simultaneous ms and branch: only the freeze is applied. The flush happens in the first non-stalled cycle.
- i_dmem_ready=1 in the cycle of i_mem_req means no stall and no state change.

## Structure
- Add to common: typedef enum logic [1:0] {CTRL_RUN, CTRL_MEM_WAIT, CTRL_HALT} ctrl_state_t. Reuse RESET.
- Sub-module load_use_detect: purely combinational lu comparator, reusable by a future forwarding unit.
- Stage registers gain en and flush inputs. Flush has priority over en, and rst has priority over both.

## Test plan
- lw x5 in EX, add x6,x5,x1 in ID (rs1=5, uses_rs1=1) → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all en=1; o_stall_cycles=1.
- Same, but rd=0, or uses_rs1=0 with rs1 matching → no stall.
- Branch taken together with lu → if_id_flush=id_ex_flush=1, pc_en=1, o_flush_count=1, o_stall_cycles=0.
- MAX_WAIT=4, i_mem_req=1, i_dmem_ready low 3 cycles then high → 3 frozen cycles with mem_wb_flush=1, return to RUN, o_halt=0, o_stall_cycles=3.
- MAX_WAIT=4, i_dmem_ready held low → 4 frozen cycles, o_halt=1 from cycle 5, all en=0; rst for 1 cycle → RUN, o_halt=0, counters 0.
- CNT_W=4, 20 load-use stalls → o_stall_cycles saturates at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: reset polarity and controller states.
package pipeline_ctrl_pkg;

    localparam logic RESET = 1'b1;

    typedef enum logic [1:0] {
        CTRL_RUN,
        CTRL_MEM_WAIT,
        CTRL_HALT
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use comparator: an EX load whose rd is read by the ID instruction.
module load_use_detect (
    input  logic [4:0] i_id_rs1_sel,
    input  logic [4:0] i_id_rs2_sel,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic [4:0] i_ex_rd_sel,
    input  logic       i_ex_ctrl_mem_read,
    input  logic       i_ex_ctrl_reg_wr_en,
    output logic       o_load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = i_id_uses_rs1 && (i_id_rs1_sel == i_ex_rd_sel);
    assign rs2_hit    = i_id_uses_rs2 && (i_id_rs2_sel == i_ex_rd_sel);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign o_load_use = i_ex_ctrl_mem_read && i_ex_ctrl_reg_wr_en &&
                        (i_ex_rd_sel != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: per-stage enable/flush for load-use, branch flush and
// data-memory wait states, with memory-timeout halt and saturating performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_id_rs1_sel,
    input  logic [4:0]       i_id_rs2_sel,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    input  logic [4:0]       i_ex_rd_sel,
    input  logic             i_ex_ctrl_mem_read,
    input  logic             i_ex_ctrl_reg_wr_en,
    input  logic             i_ex_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_dmem_ready,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_id_ex_en,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic             o_mem_wb_flush,
    output logic             o_halt,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam logic [7:0]       WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    ctrl_state_t      state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu;
    logic             ms;

    load_use_detect u_load_use_detect (
        .i_id_rs1_sel        (i_id_rs1_sel),
        .i_id_rs2_sel        (i_id_rs2_sel),
        .i_id_uses_rs1       (i_id_uses_rs1),
        .i_id_uses_rs2       (i_id_uses_rs2),
        .i_ex_rd_sel         (i_ex_rd_sel),
        .i_ex_ctrl_mem_read  (i_ex_ctrl_mem_read),
        .i_ex_ctrl_reg_wr_en (i_ex_ctrl_reg_wr_en),
        .o_load_use          (lu)
    );

    assign ms = i_mem_req && !i_dmem_ready;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_id_ex_en     = 1'b1;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_en    = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_mem_wb_flush = 1'b0;

        if (rst == RESET) begin
            {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en} = '0;
            {o_if_id_flush, o_id_ex_flush, o_mem_wb_flush}              = '1;
        end else if (state_q == CTRL_HALT) begin
            {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en} = '0;
        end else if (ms) begin
            // Freeze everything up to MEM; a taken branch waits in EX until the access completes.
            {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en} = '0;
            o_mem_wb_flush = 1'b1;
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (state_q == CTRL_RUN) begin
                state_d    = CTRL_MEM_WAIT;
                wait_cnt_d = 8'd1;
            end else if (wait_cnt_q == WAIT_LAST) begin
                state_d    = CTRL_HALT;
                wait_cnt_d = 8'd0;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else begin
            state_d    = CTRL_RUN;
            wait_cnt_d = 8'd0;
            if (i_ex_branch_taken) begin
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
                if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else if (lu) begin
                o_pc_en       = 1'b0;
                o_if_id_en    = 1'b0;
                o_id_ex_flush = 1'b1;
                if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            state_q     <= CTRL_RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_halt         = (state_q == CTRL_HALT);
    assign o_stall_cycles = stall_cnt_q;
    assign o_flush_count  = flush_cnt_q;

endmodule
